// File: rtl/lsu_unit.sv
// Load/store unit: funct3 decode, byte-lane steering, word-split accesses
// and load extraction over a 1-cycle-latency word memory port.
module lsu_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE0,
        S_ISSUE1,
        S_CAPT,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic              r_we;
    logic [2:0]        r_f3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_lo;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic              w_req_legal;
    logic [1:0]        w_off;
    logic [3:0]        w_smask;
    logic [7:0]        w_mask8;
    logic              w_split;
    logic [31:0]       w_wsz;
    logic [63:0]       w_wd64;
    logic [ADDR_W-3:0] w_waddr0;
    logic [ADDR_W-3:0] w_waddr1;
    logic [31:0]       w_lo_n;
    logic [31:0]       w_hi_n;
    logic [31:0]       w_sh;
    logic [31:0]       w_ext;

    always_comb begin
        w_req_legal = 1'b0;
        if (req_we) begin
            unique case (req_funct3)
                3'b000, 3'b001, 3'b010: w_req_legal = 1'b1;
                default:                w_req_legal = 1'b0;
            endcase
        end else begin
            unique case (req_funct3)
                3'b000, 3'b001, 3'b010,
                3'b100, 3'b101:         w_req_legal = 1'b1;
                default:                w_req_legal = 1'b0;
            endcase
        end
    end

    assign w_off = r_addr[1:0];

    always_comb begin
        w_smask = 4'b1111;
        w_wsz   = r_wdata;
        unique case (r_f3[1:0])
            2'b00: begin
                w_smask = 4'b0001;
                w_wsz   = {24'b0, r_wdata[7:0]};
            end
            2'b01: begin
                w_smask = 4'b0011;
                w_wsz   = {16'b0, r_wdata[15:0]};
            end
            default: begin
                w_smask = 4'b1111;
                w_wsz   = r_wdata;
            end
        endcase
    end

    assign w_mask8  = {4'b0, w_smask} << w_off;
    assign w_split  = |w_mask8[7:4];
    assign w_wd64   = {32'b0, w_wsz} << {w_off, 3'b000};
    assign w_waddr0 = r_addr[ADDR_W-1:2];
    assign w_waddr1 = w_waddr0 + (ADDR_W-2)'(1);

    // In CAPT, mem_rdata carries the high word for splits, the only word otherwise
    assign w_lo_n = w_split ? r_lo : mem_rdata;
    assign w_hi_n = w_split ? mem_rdata : 32'b0;
    assign w_sh   = 32'({w_hi_n, w_lo_n} >> {w_off, 3'b000});

    always_comb begin
        w_ext = w_sh;
        unique case (r_f3)
            3'b000:  w_ext = {{24{w_sh[7]}}, w_sh[7:0]};
            3'b001:  w_ext = {{16{w_sh[15]}}, w_sh[15:0]};
            3'b100:  w_ext = {24'b0, w_sh[7:0]};
            3'b101:  w_ext = {16'b0, w_sh[15:0]};
            default: w_ext = w_sh;
        endcase
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_be     = 4'b0;
        mem_wdata  = 32'b0;
        unique case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    w_next = w_req_legal ? S_ISSUE0 : S_RESP;
            end
            S_ISSUE0: begin
                mem_addr  = w_waddr0;
                mem_be    = w_mask8[3:0];
                mem_re    = ~r_we;
                mem_we    = r_we;
                mem_wdata = r_we ? w_wd64[31:0] : 32'b0;
                if (w_split)
                    w_next = S_ISSUE1;
                else
                    w_next = r_we ? S_RESP : S_CAPT;
            end
            S_ISSUE1: begin
                mem_addr  = w_waddr1;
                mem_be    = w_mask8[7:4];
                mem_re    = ~r_we;
                mem_we    = r_we;
                mem_wdata = r_we ? w_wd64[63:32] : 32'b0;
                w_next    = r_we ? S_RESP : S_CAPT;
            end
            S_CAPT: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                w_next     = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_f3    <= 3'b0;
            r_addr  <= '0;
            r_wdata <= 32'b0;
            r_lo    <= 32'b0;
            r_rdata <= 32'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && req_valid) begin
                r_we    <= req_we;
                r_f3    <= req_funct3;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                if (!w_req_legal) begin
                    r_rdata <= 32'b0;
                    r_err   <= 1'b1;
                end
            end
            if (r_state == S_ISSUE1 && !r_we)
                r_lo <= mem_rdata;
            if (r_state == S_CAPT) begin
                r_rdata <= w_ext;
                r_err   <= 1'b0;
            end
            // Stores go straight from an issue state to RESP
            if ((r_state == S_ISSUE0 || r_state == S_ISSUE1)
                && w_next == S_RESP) begin
                r_rdata <= 32'b0;
                r_err   <= 1'b0;
            end
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule
